logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  - Parametrised, pipelined bitwise logic unit for the ALU datapath; successor to the fixed 8-bit AND.
//  - Supports 8 logic ops selected per transaction, built from SLICE-wide slices.
//  - Adds result flags and valid/ready handshakes on input and output.
//  - Sits between the operand/decode stage and the ALU result mux.
// PARAMETERS
//  WIDTH   8  operand/result width; must be a multiple of SLICE (elaboration error otherwise)
//  SLICE   4  width of one logic_slice instance; WIDTH/SLICE instances generated
//  STAGES  1  pipeline register depth, legal 1..4; latency in cycles
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      unit accepts this cycle (transfer = in_valid & in_ready)
//  in_op      in   3      op select (encoding below)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B (ignored for NOTA)
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts (transfer = out_valid & out_ready)
//  out_data   out  WIDTH  result
//  out_zero   out  1      out_data == 0
//  out_ones   out  1      out_data == all ones
//  out_par    out  1      XOR-reduce of out_data (odd parity = 1)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Ops: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (a & ~b), 111 NOTA (~a).
//  - Result and flags computed combinationally from in_* and captured with op in stage 0.
//  - Stages 1..STAGES-1 forward data and flags unchanged.
//  - Each stage k has valid bit v[k]; out_valid = v[STAGES-1].
//  - Stage k loads when !v[k] or stage k advances out; last stage advances when out_ready.
//  - in_ready = !v[0] | stage-0-advance; combinational from out_ready through the chain
//    (no skid buffer).
//  - Full throughput: 1 transfer/cycle with out_ready held high.
//  - Latency: a transfer at cycle t appears with out_valid at t+STAGES.
//  - Stall: while out_valid & !out_ready, out_data and flags hold stable.
//  - Pipeline fills to STAGES entries, then in_ready=0.
//  - Simultaneous out transfer and in transfer on a full pipe: both occur, no bubble.
//  - Reset: all v[k]=0, out_valid=0, out_data=0, out_zero=0, out_ones=0, out_par=0.
//    in_ready=1 from the first cycle after reset.
//  - Reset mid-operation: in-flight results are discarded, not delivered.
//    in_valid during rst is not captured.
//  - Flags are 0 whenever out_valid=0; data registers load only on stage load
//    (no toggling when idle).
//  - Undefined in_op is impossible (3-bit fully decoded); X on in_op while in_valid=1
//    is a bench assertion failure.
// STRUCTURE
//  - Package alu_logic_pkg: op localparams LOP_AND..LOP_NOTA, LOP_W=3, shared with the ALU
//    decoder.
//  - Sub-module logic_slice #(.W(SLICE)): combinational (op, a, b) -> y.
//    Generate loop over WIDTH/SLICE instances.
//  - Flag reduction and valid/ready pipeline live in logic_unit_pipe.
// TESTING
//  - Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, flags 0;
//    in_ready=1 after release.
//  - All ops, WIDTH=8: a=8'hC5, b=8'h3A ->
//    AND 00 (zero=1), OR FF (ones=1), XOR FF, NAND FF, NOR 00, XNOR 00, ANDN C5 (par=0),
//    NOTA 3A (par=0).
//  - Latency/throughput: STAGES=3, out_ready=1, 10 back-to-back ops ->
//    first out_valid 3 cycles after first transfer, then 10 consecutive results in order.
//  - Backpressure: STAGES=2, out_ready=0 -> accepts exactly 2 ops then in_ready=0;
//    out_data stable; on release, results drain in order with no loss or duplication.
//  - Reset mid-flight: STAGES=3, 3 ops in pipe, pulse rst 1 cycle ->
//    none of the 3 results ever appear on the output.
//  - Width scaling: WIDTH=32, SLICE=8, a=32'hFFFF_0000, b=32'h0F0F_0F0F, XOR ->
//    F0F0_0F0F, zero=0, ones=0, par=0; random 1000-op run checked against reference model.

Source files
------------

// File: rtl/alu_logic_pkg.sv
// ---------------------------------------------------------------------------
// alu_logic_pkg
//   Operation encoding for the ALU logic unit. The ALU decoder imports the
//   same constants, so the encoding is defined in one place only.
//   No ports: the package holds constants only.
// ---------------------------------------------------------------------------
package alu_logic_pkg;

    localparam int LOP_W = 3;

    localparam logic [LOP_W-1:0] LOP_AND  = 3'b000;
    localparam logic [LOP_W-1:0] LOP_OR   = 3'b001;
    localparam logic [LOP_W-1:0] LOP_XOR  = 3'b010;
    localparam logic [LOP_W-1:0] LOP_NAND = 3'b011;
    localparam logic [LOP_W-1:0] LOP_NOR  = 3'b100;
    localparam logic [LOP_W-1:0] LOP_XNOR = 3'b101;
    localparam logic [LOP_W-1:0] LOP_ANDN = 3'b110;   // a & ~b
    localparam logic [LOP_W-1:0] LOP_NOTA = 3'b111;   // ~a, b ignored

endpackage

// File: rtl/logic_slice.sv
// ---------------------------------------------------------------------------
// logic_slice
//   Purely combinational W-bit bitwise logic slice. The logic unit tiles
//   these to build its full operand width.
// Ports
//   op  in  LOP_W  operation select (alu_logic_pkg encoding)
//   a   in  W      operand A
//   b   in  W      operand B (unused for NOTA)
//   y   out W      result
// ---------------------------------------------------------------------------
module logic_slice
    import alu_logic_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [LOP_W-1:0] op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [W-1:0]     y
);

    always_comb begin
        y = '0;
        case (op)
            LOP_AND:  y = a & b;
            LOP_OR:   y = a | b;
            LOP_XOR:  y = a ^ b;
            LOP_NAND: y = ~(a & b);
            LOP_NOR:  y = ~(a | b);
            LOP_XNOR: y = ~(a ^ b);
            LOP_ANDN: y = a & ~b;
            default:  y = ~a;        // LOP_NOTA, the only remaining code
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//   Pipelined bitwise logic unit for the ALU datapath. The result and its
//   flags are computed combinationally from the inputs and captured in
//   stage 0. Stages 1..STAGES-1 only forward them. Latency is STAGES cycles,
//   with full throughput while out_ready is high.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
//   are both high. The producer holds its payload stable while valid is high
//   and ready is low. in_ready is combinational from out_ready through the
//   stage chain; there is no skid buffer. Stage k loads when it is empty or
//   when its own content moves downstream in the same cycle. A full pipe can
//   therefore accept and deliver in the same cycle without a bubble.
//
// Ports
//   clk        in   1      clock, all state on posedge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands/op presented
//   in_ready   out  1      unit accepts this cycle
//   in_op      in   3      op select (alu_logic_pkg encoding)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   out_valid  out  1      result available
//   out_ready  in   1      consumer accepts
//   out_data   out  WIDTH  result
//   out_zero   out  1      out_data == 0        (0 while out_valid=0)
//   out_ones   out  1      out_data == all ones (0 while out_valid=0)
//   out_par    out  1      XOR-reduce of out_data (0 while out_valid=0)
// ---------------------------------------------------------------------------
module logic_unit_pipe
    import alu_logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SLICE  = 4,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOP_W-1:0] in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par
);

    localparam int NSL = WIDTH / SLICE;

    if ((WIDTH % SLICE) != 0) begin : g_bad_width
        $error("logic_unit_pipe: WIDTH must be a multiple of SLICE");
    end
    if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
        $error("logic_unit_pipe: STAGES must be in 1..4");
    end

    // Combinational result from the slice array.
    logic [WIDTH-1:0] y_c;

    for (genvar s = 0; s < NSL; s++) begin : g_slice
        logic_slice #(.W(SLICE)) u_slice (
            .op (in_op),
            .a  (in_a[s*SLICE +: SLICE]),
            .b  (in_b[s*SLICE +: SLICE]),
            .y  (y_c[s*SLICE +: SLICE])
        );
    end

    logic zero_c;
    logic ones_c;
    logic par_c;

    assign zero_c = ~|y_c;
    assign ones_c = &y_c;
    assign par_c  = ^y_c;

    // Pipeline state
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] zero_q;
    logic [STAGES-1:0] ones_q;
    logic [STAGES-1:0] par_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    // load[k]: stage k takes new content at the next edge. This is true when
    // the stage is empty or its content leaves, so the readiness of
    // everything downstream ripples back as one carry.
    logic [STAGES-1:0] load;

    always_comb begin
        logic carry;
        load  = '0;
        carry = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = ~v_q[k] | carry;
            carry   = ~v_q[k] | carry;
        end
    end

    assign in_ready = load[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            zero_q <= '0;
            ones_q <= '0;
            par_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            // Stage 0 captures from the input port.
            if (load[0]) begin
                v_q[0] <= in_valid;
            end
            if (load[0] && in_valid) begin
                data_q[0] <= y_c;
                zero_q[0] <= zero_c;
                ones_q[0] <= ones_c;
                par_q[0]  <= par_c;
            end
            // Later stages forward. Payload registers change only when a
            // valid entry actually moves in, so they stay quiet when idle.
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= v_q[k-1];
                end
                if (load[k] && v_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                    zero_q[k] <= zero_q[k-1];
                    ones_q[k] <= ones_q[k-1];
                    par_q[k]  <= par_q[k-1];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    // Flags are qualified with valid so they read 0 whenever nothing is
    // presented, even though the last payload remains in the registers.
    assign out_zero  = v_q[STAGES-1] & zero_q[STAGES-1];
    assign out_ones  = v_q[STAGES-1] & ones_q[STAGES-1];
    assign out_par   = v_q[STAGES-1] & par_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Three instances of logic_unit_pipe share one clock and reset:
//     0: WIDTH=8,  SLICE=4, STAGES=3  (reset, op table, latency, reset mid-flight)
//     1: WIDTH=8,  SLICE=4, STAGES=2  (backpressure)
//     2: WIDTH=32, SLICE=8, STAGES=1  (width scaling, random traffic)
//   A negedge monitor pushes a reference result for every input transfer.
//   It pops and compares that result on every output transfer.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [2:0]  in_op     [3];
    logic [31:0] in_a      [3];
    logic [31:0] in_b      [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic        out_zero  [3];
    logic        out_ones  [3];
    logic        out_par   [3];
    logic [7:0]  od0;
    logic [7:0]  od1;
    logic [31:0] od2;

    assign out_data[0] = {24'd0, od0};
    assign out_data[1] = {24'd0, od1};
    assign out_data[2] = od2;

    int wd [3] = '{8, 8, 32};

    logic_unit_pipe #(.WIDTH(8), .SLICE(4), .STAGES(3)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
        .in_a(in_a[0][7:0]), .in_b(in_b[0][7:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0),
        .out_zero(out_zero[0]), .out_ones(out_ones[0]), .out_par(out_par[0])
    );

    logic_unit_pipe #(.WIDTH(8), .SLICE(4), .STAGES(2)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
        .in_a(in_a[1][7:0]), .in_b(in_b[1][7:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1),
        .out_zero(out_zero[1]), .out_ones(out_ones[1]), .out_par(out_par[1])
    );

    logic_unit_pipe #(.WIDTH(32), .SLICE(8), .STAGES(1)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_op(in_op[2]),
        .in_a(in_a[2]), .in_b(in_b[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2),
        .out_zero(out_zero[2]), .out_ones(out_ones[2]), .out_par(out_par[2])
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: whole-word op, result packed as {par, ones, zero, data}.
    function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic [31:0] mask;
        logic [31:0] y;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (op)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = a ^ b;
            3'd3:    y = ~(a & b);
            3'd4:    y = ~(a | b);
            3'd5:    y = ~(a ^ b);
            3'd6:    y = a & ~b;
            default: y = ~a;
        endcase
        y = y & mask;
        return {^y, (y == mask), (y == 32'd0), y};
    endfunction

    // ---------------- scoreboard ----------------
    logic [34:0] exp_q0[$];
    logic [34:0] exp_q1[$];
    logic [34:0] exp_q2[$];

    task automatic q_push(input int idx, input logic [34:0] val);
        case (idx)
            0:       exp_q0.push_back(val);
            1:       exp_q1.push_back(val);
            default: exp_q2.push_back(val);
        endcase
    endtask

    task automatic q_pop(input int idx, output logic [34:0] val, output logic ok);
        val = '0;
        ok  = 1'b0;
        case (idx)
            0:       if (exp_q0.size() > 0) begin val = exp_q0.pop_front(); ok = 1'b1; end
            1:       if (exp_q1.size() > 0) begin val = exp_q1.pop_front(); ok = 1'b1; end
            default: if (exp_q2.size() > 0) begin val = exp_q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic q_clear(input int idx);
        case (idx)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endtask

    function automatic int q_size(input int idx);
        case (idx)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    // ---------------- monitor ----------------
    int          n_out [3] = '{0, 0, 0};
    logic        prev_stall [3] = '{1'b0, 1'b0, 1'b0};
    logic [34:0] prev_vec [3];
    logic        track0 = 1'b0;
    int          first_in_cyc = -1;
    int          out_cyc0[$];
    logic [34:0] mon_obs;
    logic [34:0] mon_exp;
    logic        mon_ok;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            mon_obs = {out_par[i], out_ones[i], out_zero[i], out_data[i]};
            if (rst) begin
                q_clear(i);
                prev_stall[i] = 1'b0;
            end else begin
                if (in_valid[i] && $isunknown(in_op[i]))
                    check("op_x", {61'd0, in_op[i]}, 64'd0);
                if (prev_stall[i])
                    check("stall_hold", {29'd0, out_valid[i], mon_obs}, {29'd1, prev_vec[i]});
                if (!out_valid[i])
                    check("idle_flags", {61'd0, mon_obs[34:32]}, 64'd0);
                if (in_valid[i] && in_ready[i]) begin
                    q_push(i, model(in_op[i], in_a[i], in_b[i], wd[i]));
                    if (i == 0 && track0 && first_in_cyc < 0) first_in_cyc = cyc;
                end
                if (out_valid[i] && out_ready[i]) begin
                    q_pop(i, mon_exp, mon_ok);
                    check("out_expected", {63'd0, mon_ok}, 64'd1);
                    if (mon_ok) check("out_data", {29'd0, mon_obs}, {29'd0, mon_exp});
                    n_out[i]++;
                    if (i == 0 && track0) out_cyc0.push_back(cyc);
                end
                prev_stall[i] = out_valid[i] && !out_ready[i];
                prev_vec[i]   = mon_obs;
            end
        end
    end

    // ---------------- driver tasks (all start and end at posedge+1) ----------------
    task automatic send(input int idx, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        logic ok;
        ok = 1'b0;
        in_valid[idx] = 1'b1;
        in_op[idx]    = op;
        in_a[idx]     = a;
        in_b[idx]     = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready[idx];
            @(posedge clk); #1;
        end
        in_valid[idx] = 1'b0;
        check("send_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic run_one(input int idx, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [34:0] exp);
        logic found;
        found = 1'b0;
        out_ready[idx] = 1'b1;
        send(idx, op, a, b);
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = out_valid[idx];
        end
        check("result_timeout", {63'd0, found}, 64'd1);
        check("directed_result",
              {29'd0, out_par[idx], out_ones[idx], out_zero[idx], out_data[idx]},
              {29'd0, exp});
        @(posedge clk); #1;
    endtask

    // op table for a=C5, b=3A on WIDTH=8: data and {par, ones, zero}
    logic [7:0] tbl_res [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC5, 8'h3A};
    logic [2:0] tbl_flg [8] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b000, 3'b000};

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        int n_before;
        int sent;
        logic acc_flag;

        // Reset held two cycles with in_valid high on every instance
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b1;
            in_op[i]     = 3'd1;
            in_a[i]      = 32'hFFFF_FFFF;
            in_b[i]      = 32'h0;
            out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_out_valid", {63'd0, out_valid[i]}, 64'd0);
            check("rst_out_data", {32'd0, out_data[i]}, 64'd0);
            check("rst_flags", {61'd0, out_par[i], out_ones[i], out_zero[i]}, 64'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", {63'd0, in_ready[i]}, 64'd1);
            check("rst_no_capture", {63'd0, out_valid[i]}, 64'd0);
        end
        @(posedge clk); #1;

        // All ops, a=C5 b=3A, on instance 0
        for (int op = 0; op < 8; op++)
            run_one(0, op[2:0], 32'hC5, 32'h3A, {tbl_flg[op], 24'd0, tbl_res[op]});

        // Latency / throughput: 10 back-to-back ops on STAGES=3
        out_cyc0.delete();
        first_in_cyc = -1;
        track0 = 1'b1;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 10; k++)
            send(0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        for (int k = 0; k < 20 && out_cyc0.size() < 10; k++) begin
            @(posedge clk); #1;
        end
        track0 = 1'b0;
        check("lat_count", out_cyc0.size(), 10);
        if (out_cyc0.size() == 10) begin
            check("lat_first", out_cyc0[0] - first_in_cyc, 3);
            for (int k = 1; k < 10; k++)
                check("lat_consecutive", out_cyc0[k] - out_cyc0[0], k);
        end

        // Backpressure on STAGES=2
        out_ready[1] = 1'b0;
        acc = 0;
        in_valid[1] = 1'b1;
        in_op[1] = 3'($urandom_range(0, 7));
        in_a[1] = $urandom;
        in_b[1] = $urandom;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc_flag = in_ready[1];
            @(posedge clk); #1;
            if (acc_flag) begin
                acc++;
                in_op[1] = 3'($urandom_range(0, 7));
                in_a[1] = $urandom;
                in_b[1] = $urandom;
            end
        end
        in_valid[1] = 1'b0;
        check("bp_accepted", acc, 2);
        check("bp_in_ready", {63'd0, in_ready[1]}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid[1]}, 64'd1);
        n_before = n_out[1];
        out_ready[1] = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("bp_drained", n_out[1] - n_before, 2);
        check("bp_q_empty", q_size(1), 0);

        // Reset mid-flight: fill STAGES=3, pulse reset, nothing may come out
        out_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++)
            send(0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        check("mf_full", {63'd0, out_valid[0]}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_before = n_out[0];
        out_ready[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("mf_no_output", n_out[0] - n_before, 0);
        check("mf_out_valid", {63'd0, out_valid[0]}, 64'd0);

        // Width scaling on WIDTH=32
        run_one(2, 3'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, {3'b000, 32'hF0F0_0F0F});

        // Random 1000-op run on WIDTH=32 with random valid and ready
        n_before = n_out[2];
        sent = 0;
        acc_flag = 1'b0;
        in_valid[2] = 1'b0;
        for (int c = 0; c < 8000 && sent < 1000; c++) begin
            if (!in_valid[2] || acc_flag) begin
                in_valid[2] = ($urandom_range(0, 3) != 0);
                in_op[2] = 3'($urandom_range(0, 7));
                in_a[2] = $urandom;
                in_b[2] = $urandom;
            end
            out_ready[2] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_flag = in_valid[2] && in_ready[2];
            if (acc_flag) sent++;
            @(posedge clk); #1;
        end
        in_valid[2] = 1'b0;
        out_ready[2] = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("rand_sent", sent, 1000);
        check("rand_delivered", n_out[2] - n_before, sent);
        check("rand_q_empty", q_size(2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
